// File: rtl/synch_ram_arbiter.sv
// Two-port round-robin front end for a single-port synchronous byte RAM.
// One operation issues per cycle. Each response returns one cycle after acceptance, and out-of-range addresses are trapped.
module synch_ram_arbiter #(
  parameter int MEM_DEPTH = 10000,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;
  // One extra bit so that MEM_DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [NUM_PORTS-1:0]              rq;
  req_t                              sel;
  logic [NUM_PORTS-1:0]              req, gnt, rvalid, err;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata;
  logic                              acc, inr;

  // prio_q: 0 = port 0 preferred. The response tag is {rd_q|err_q, port_q, err_q}.
  logic prio_q, prio_d;
  logic rd_q, rd_d, err_q, err_d, port_q, port_d;

  assign rq[0] = {r0_we, r0_addr, r0_wdata};
  assign rq[1] = {r1_we, r1_addr, r1_wdata};
  assign req   = {r1_req, r0_req};

  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (req[0] && (!req[1] || !prio_q)) gnt[0] = 1'b1;
      else if (req[1])                    gnt[1] = 1'b1;
    end
    acc       = |gnt;
    sel       = gnt[1] ? rq[1] : rq[0];
    inr       = {1'b0, sel.addr} < DEPTH;
    mem_cs    = acc & inr;
    mem_we    = mem_cs & sel.we;
    mem_re    = mem_cs & ~sel.we;
    mem_addr  = sel.addr;
    mem_wdata = sel.wdata;
    prio_d    = acc ? gnt[0] : prio_q;
    rd_d      = acc & ~sel.we;
    err_d     = acc & ~inr;
    port_d    = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      rd_q   <= 1'b0;
      err_q  <= 1'b0;
      port_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
      port_q <= port_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    assign rvalid[p] = rd_q  & (port_q == 1'(p));
    assign err[p]    = err_q & (port_q == 1'(p));
    assign rdata[p]  = (rvalid[p] & ~err_q) ? mem_rdata : '0;
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_err    = err[0];
  assign r1_err    = err[1];
  assign r0_rdata  = rdata[0];
  assign r1_rdata  = rdata[1];
endmodule

// File: tb/tb_synch_ram_arbiter.sv
// Bench for synch_ram_arbiter: a RAM model, a cycle-level reference model with a negedge
// compare process, and directed scenarios followed by randomized traffic.
module tb_synch_ram_arbiter;
  localparam int MEM_DEPTH = 10000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [15:0] r0_addr = 0, r1_addr = 0;
  logic [7:0]  r0_wdata = 0, r1_wdata = 0;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        mem_cs, mem_we, mem_re;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int n_chk = 0, n_fail = 0;

  synch_ram_arbiter #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    logic [31:0] t;
    t = 32'(a) * 7 + 3;
    return t[7:0];
  endfunction

  // Registered-read RAM; unwritten locations hold init_val(addr).
  bit         ram_wr [65536];
  logic [7:0] ram_val[65536];
  int         wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        ram_wr[mem_addr]  <= 1'b1;
        ram_val[mem_addr] <= mem_wdata;
        wr_cnt            <= wr_cnt + 1;
      end else if (mem_re) begin
        mem_rdata <= ram_wr[mem_addr] ? ram_val[mem_addr] : init_val(mem_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: preferred port, the single pending response, and the shadow memory.
  int         m_pref = 0;
  bit         p_vld = 0, p_rd = 0, p_oob = 0;
  int         p_port = 0;
  logic [7:0] p_data = 0;
  bit         sh_wr [65536];
  logic [7:0] sh_val[65536];
  bit         lg0 = 0, lg1 = 0;
  int         win, ga;
  bit         e_acc, e_inr, e_we;
  logic [7:0] e_wd;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {r0_gnt, r1_gnt, mem_cs, mem_we, mem_re,
                            r0_rvalid, r1_rvalid, r0_err, r1_err}, 0);
      m_pref = 0; p_vld = 0; lg0 = 0; lg1 = 0;
    end else begin
      if (r0_req && r1_req) win = m_pref;
      else if (r0_req)      win = 0;
      else if (r1_req)      win = 1;
      else                  win = -1;
      e_acc = (win >= 0);
      ga    = (win == 1) ? int'(r1_addr) : int'(r0_addr);
      e_we  = (win == 1) ? r1_we : r0_we;
      e_wd  = (win == 1) ? r1_wdata : r0_wdata;
      e_inr = ga < MEM_DEPTH;
      chk("gnt", {r0_gnt, r1_gnt}, {win == 0, win == 1});
      chk("strobes", {mem_cs, mem_we, mem_re},
          {e_acc && e_inr, e_acc && e_inr && e_we, e_acc && e_inr && !e_we});
      chk("mem_addr", mem_addr, ga);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("rvalid", {r0_rvalid, r1_rvalid},
          {p_vld && p_rd && p_port == 0, p_vld && p_rd && p_port == 1});
      chk("err", {r0_err, r1_err},
          {p_vld && p_oob && p_port == 0, p_vld && p_oob && p_port == 1});
      if (p_vld && p_rd && p_port == 0) chk("r0_rdata", r0_rdata, p_oob ? 8'h00 : p_data);
      if (p_vld && p_rd && p_port == 1) chk("r1_rdata", r1_rdata, p_oob ? 8'h00 : p_data);
      // Advance the model to the state after the coming posedge.
      p_vld = e_acc;
      if (e_acc) begin
        m_pref = 1 - win;
        p_port = win;
        p_rd   = !e_we;
        p_oob  = !e_inr;
        p_data = e_inr ? (sh_wr[ga] ? sh_val[ga] : init_val(16'(ga))) : 8'h00;
        if (e_we && e_inr) begin
          sh_wr[ga]  = 1'b1;
          sh_val[ga] = e_wd;
        end
      end
      lg0 = (win == 0);
      lg1 = (win == 1);
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk); #1; endtask

  function automatic logic [15:0] raddr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6)      return 16'($urandom_range(0, 31));
    else if (s < 8) return 16'($urandom_range(MEM_DEPTH - 2, MEM_DEPTH + 1));
    else            return 16'($urandom_range(0, 65535));
  endfunction

  int wc;

  initial begin
    repeat (3) @(posedge clk);
    smp;
    chk("rst_r0_rvalid", r0_rvalid, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt}, 0);

    // Write 0x5A to 0x0010, then read it back.
    tick; rst_n = 1; r0_req = 1; r0_we = 1; r0_addr = 16'h0010; r0_wdata = 8'h5A;
    smp;
    chk("wr_gnt", r0_gnt, 1);
    chk("wr_strobe", {mem_cs, mem_we, mem_re}, 3'b110);
    chk("wr_addr", mem_addr, 16'h0010);
    chk("wr_wdata", mem_wdata, 8'h5A);
    tick; r0_we = 0;
    smp;
    chk("rd_gnt", r0_gnt, 1);
    chk("wr_no_rsp", {r0_rvalid, r0_err}, 0);
    tick; r0_req = 0;
    smp;
    chk("rd_rvalid", r0_rvalid, 1);
    chk("rd_rdata", r0_rdata, 8'h5A);
    chk("rd_r1_quiet", r1_rvalid, 0);

    // Both ports read for four cycles from reset: r0, r1, r0, r1.
    tick; rst_n = 0;
    tick; rst_n = 1;
    r0_req = 1; r0_we = 0; r0_addr = 16'h0020;
    r1_req = 1; r1_we = 0; r1_addr = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk("rr_gnt", {r0_gnt, r1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k == 1) begin
        chk("rr_rv0", {r0_rvalid, r1_rvalid}, 2'b10);
        chk("rr_rd0", r0_rdata, 8'hE3);
      end
      if (k == 2) begin
        chk("rr_rv1", {r0_rvalid, r1_rvalid}, 2'b01);
        chk("rr_rd1", r1_rdata, 8'h53);
      end
      tick;
    end
    r0_req = 0; r1_req = 0;
    smp;
    chk("rr_last_rv", {r0_rvalid, r1_rvalid}, 2'b01);
    chk("rr_last_rd", r1_rdata, 8'h53);

    // Boundary addresses on port 1.
    tick; r1_req = 1; r1_we = 0; r1_addr = 16'(MEM_DEPTH - 1);
    smp;
    chk("b9999_gnt", r1_gnt, 1);
    chk("b9999_re", {mem_cs, mem_re}, 2'b11);
    tick; r1_addr = 16'(MEM_DEPTH);
    smp;
    chk("b10000_gnt", r1_gnt, 1);
    chk("b10000_cs", mem_cs, 0);
    chk("b9999_rsp", {r1_rvalid, r1_err}, 2'b10);
    chk("b9999_data", r1_rdata, 8'h6C);
    wc = wr_cnt;
    tick; r1_we = 1; r1_addr = 16'hFFFF; r1_wdata = 8'h77;
    smp;
    chk("oobw_gnt", r1_gnt, 1);
    chk("oobw_cs", {mem_cs, mem_we}, 0);
    chk("b10000_rsp", {r1_rvalid, r1_err}, 2'b11);
    chk("b10000_data", r1_rdata, 8'h00);
    tick; r1_we = 0; r1_addr = 16'h0010;
    smp;
    chk("oobw_rsp", {r1_rvalid, r1_err}, 2'b01);
    tick; r1_req = 0;
    smp;
    chk("oobw_nowrite", wr_cnt, wc);
    chk("readback", {r1_rvalid, r1_err, r1_rdata}, {2'b10, 8'h5A});

    // Reset while a read response is pending.
    tick; r0_req = 1; r0_we = 0; r0_addr = 16'h0020;
    smp;
    chk("rstmid_gnt", r0_gnt, 1);
    tick; rst_n = 0; r0_req = 0;
    smp;
    chk("rstmid_drop", r0_rvalid, 0);
    tick;
    smp;
    chk("rstmid_drop2", r0_rvalid, 0);
    tick; rst_n = 1; r0_req = 1; r1_req = 1; r1_we = 0; r1_addr = 16'h0030;
    smp;
    chk("rstmid_prio", {r0_gnt, r1_gnt}, 2'b10);
    tick; r0_req = 0; r1_req = 0;

    // Randomized traffic with occasional resets; fields hold until granted.
    for (int c = 0; c < 3000; c++) begin
      tick;
      rst_n = ($urandom_range(0, 299) != 0);
      if (!(r0_req && !lg0)) begin
        r0_req = ($urandom_range(0, 3) != 0); r0_we = 1'($urandom_range(0, 1));
        r0_addr = raddr(); r0_wdata = 8'($urandom);
      end
      if (!(r1_req && !lg1)) begin
        r1_req = ($urandom_range(0, 3) != 0); r1_we = 1'($urandom_range(0, 1));
        r1_addr = raddr(); r1_wdata = 8'($urandom);
      end
    end
    tick; rst_n = 1; r0_req = 0; r1_req = 0;
    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/synch_ram_arbiter.md
Name: synch_ram_arbiter

Overview:
- Two-port round-robin arbiter in front of the single-port synchronous byte RAM: 16-bit address, 8-bit data, registered read.
- Lets two requesters share the RAM through a req/gnt handshake, e.g. port 0 = CPU, port 1 = loader/DMA.
- Issues at most one RAM operation per cycle and routes each read response back to its originating port one cycle later.
- Traps out-of-range addresses so they never reach the RAM.

Parameters:
- MEM_DEPTH, 10000: number of valid RAM locations; addresses >= MEM_DEPTH are out of range.
- ADDR_W, 16: address width.
- DATA_W, 8: data width.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- r0_req  in  1  port 0 request; holds its fields stable until granted.
- r0_we  in  1  port 0 operation: 1 = write, 0 = read.
- r0_addr  in  ADDR_W  port 0 address.
- r0_wdata  in  DATA_W  port 0 write data.
- r0_gnt  out  1  port 0 request accepted this cycle.
- r0_rvalid  out  1  port 0 read data valid (read response).
- r0_rdata  out  DATA_W  port 0 read data.
- r0_err  out  1  port 0 out-of-range error response.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err: same signals for port 1.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM registered read data.

Behaviour:
- Reset, with rst_n low asynchronously:
  - rvalid/err on both ports = 0.
  - Priority pointer = port 0 preferred.
  - Response tag cleared.
  - While rst_n is low, gnt and mem_cs/mem_we/mem_re are forced to 0.
- Arbitration is combinational within the cycle:
  - Only one port requesting: that port is granted.
  - Both requesting: the preferred port is granted.
  - A transaction is accepted when req and gnt are both high at posedge.
  - On acceptance the pointer moves to the other port, so the granted port becomes least preferred.
  - With no acceptance the pointer holds.
- Issue, same cycle as gnt for an in-range address (addr < MEM_DEPTH):
  - mem_cs = 1, mem_we = we, mem_re = ~we.
  - mem_addr/mem_wdata = fields of the granted port.
- Out-of-range grant:
  - gnt still asserts.
  - mem_cs/mem_we/mem_re stay 0 and the RAM is untouched.
  - Next cycle that port gets err = 1 (reads also rvalid = 1 with rdata = 0; writes err only).
- Idle cycles: mem_cs/mem_we/mem_re = 0; mem_addr/mem_wdata = port 0 fields (don't-care).
- Read response:
  - A registered tag {valid, port, oob} records the accepted read.
  - Next cycle the tagged port's rvalid = 1 for exactly one cycle.
  - rdata = mem_rdata combinationally; the untagged port keeps rvalid = 0.
  - rdata is only meaningful while rvalid = 1.
- Write response: no rvalid. err is a one-cycle pulse, only on out-of-range.
- Throughput: one accepted transaction per cycle, back-to-back, any mix. The tag is overwritten each cycle, so the fixed 1-cycle latency means no response queue.
- Simultaneous accept plus pending response: allowed. The cycle N+1 response belongs to the cycle N acceptance while the cycle N+1 acceptance issues.
- Reset mid-operation: a pending response is dropped (rvalid never asserts). Priority returns to port 0.
- Address compare is unsigned full-width ADDR_W against MEM_DEPTH. MEM_DEPTH = 2^ADDR_W means nothing is out of range.

Test Plan:
- Reset, then only r0 writes 0x5A to 0x0010 -> r0_gnt same cycle; mem_cs=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x5A; no rvalid/err.
- r0 reads 0x0010 after that write -> next cycle r0_rvalid=1, r0_rdata=0x5A; r1_rvalid stays 0.
- r0 and r1 both hold read requests for 4 cycles from reset -> grants alternate r0, r1, r0, r1; rvalid follows one cycle behind on the matching port, and each rdata matches that port's address.
- r1 reads 9999 then 10000 with MEM_DEPTH=10000:
  - 9999 -> mem_re=1, then valid data.
  - 10000 -> gnt=1 but mem_cs=0, then r1_rvalid=1, r1_err=1, r1_rdata=0x00.
- r1 writes 0xFFFF -> gnt, no RAM strobe, r1_err pulses one cycle later; memory contents unchanged on readback.
- r0 read accepted, rst_n pulled low before the next posedge -> r0_rvalid never asserts; after release, a simultaneous r0/r1 request grants r0 first.
